// File: rtl/tick_irq_scheduler_if.sv
// Bus between the CPU port registers and tick_irq_scheduler: configuration strobes,
// acknowledge, and the interrupt request/status returned to the MCU.
interface tick_irq_scheduler_if #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 16
);
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic             cfg_we;
    logic [IW-1:0]    cfg_idx;
    logic [CNT_W-1:0] cfg_period;
    logic             en_we;
    logic [N_SRC-1:0] en_wdata;
    logic             ack;
    logic             ovr_clr;
    logic             ei_req;
    logic [IW-1:0]    irq_id;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] overrun;

    modport master (
        output cfg_we, cfg_idx, cfg_period, en_we, en_wdata, ack, ovr_clr,
        input  ei_req, irq_id, pending, overrun
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_period, en_we, en_wdata, ack, ovr_clr,
        output ei_req, irq_id, pending, overrun
    );
endinterface

// File: rtl/tick_irq_scheduler.sv
// N programmable periodic tick sources feeding a fixed-priority (index 0 highest)
// interrupt presenter with ack handshake and a one-clock request gap between sources.
module tick_irq_scheduler #(
    parameter int N_SRC      = 4,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 6249,
    parameter int EN_RST     = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tick_irq_scheduler_if.slave  bus
);
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_GAP
    } state_t;

    logic [CNT_W-1:0] r_cnt    [N_SRC];
    logic [CNT_W-1:0] r_period [N_SRC];
    logic [N_SRC-1:0] r_en;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_overrun;
    logic             r_ei_req;
    logic [IW-1:0]    r_irq_id;
    state_t           r_state;

    logic [N_SRC-1:0] w_tick;
    logic [N_SRC-1:0] w_cfg_hit;
    logic [N_SRC-1:0] w_clr;
    logic [IW-1:0]    w_lowest;
    state_t           w_state_nxt;
    logic             w_ei_req_nxt;
    logic [IW-1:0]    w_irq_id_nxt;

    // A period write takes priority over the terminal-count compare for that source.
    always_comb begin
        w_cfg_hit = '0;
        w_tick    = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            w_cfg_hit[i] = bus.cfg_we && (bus.cfg_idx == IW'(i));
            w_tick[i]    = r_en[i] && (r_cnt[i] == r_period[i]) && !w_cfg_hit[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                r_cnt[i]    <= '0;
                r_period[i] <= CNT_W'(DEF_PERIOD);
            end
            r_en <= N_SRC'(EN_RST);
        end else begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (w_cfg_hit[i]) begin
                    r_period[i] <= bus.cfg_period;
                    r_cnt[i]    <= '0;
                end else if (!r_en[i] || w_tick[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            if (bus.en_we) begin
                r_en <= bus.en_wdata;
            end
        end
    end

    // A tick coinciding with the ack of its own source keeps it pending and is not an overrun.
    assign w_clr = (r_state == S_PRESENT && bus.ack) ? (N_SRC'(1) << r_irq_id) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_tick;
            r_overrun <= (bus.ovr_clr ? '0 : r_overrun) | (w_tick & r_pending & ~w_clr);
        end
    end

    always_comb begin
        w_lowest = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (r_pending[N_SRC-1-k]) begin
                w_lowest = IW'(N_SRC - 1 - k);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ei_req_nxt = r_ei_req;
        w_irq_id_nxt = r_irq_id;
        case (r_state)
            S_IDLE: begin
                if (|r_pending) begin
                    w_state_nxt  = S_PRESENT;
                    w_ei_req_nxt = 1'b1;
                    w_irq_id_nxt = w_lowest;
                end
            end
            S_PRESENT: begin
                if (bus.ack) begin
                    w_state_nxt  = S_GAP;
                    w_ei_req_nxt = 1'b0;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_ei_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ei_req <= 1'b0;
            r_irq_id <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ei_req <= w_ei_req_nxt;
            r_irq_id <= w_irq_id_nxt;
        end
    end

    assign bus.ei_req  = r_ei_req;
    assign bus.irq_id  = r_irq_id;
    assign bus.pending = r_pending;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_tick_irq_scheduler.sv
// Randomized and directed checks of tick_irq_scheduler against a cycle-level behavioural
// model built from the counter / pending / presentation rules.
module tb_tick_irq_scheduler;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IW  = 2;
    localparam int DEF = 6249;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tick_irq_scheduler_if #(.N_SRC(N), .CNT_W(W)) bus ();

    tick_irq_scheduler #(
        .N_SRC(N), .CNT_W(W), .DEF_PERIOD(DEF), .EN_RST(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_cnt [N];
    int m_per [N];
    bit m_en  [N];
    bit m_pend[N];
    bit m_ovr [N];
    int m_phase;   // 0 waiting, 1 showing a request, 2 falling-edge gap
    bit m_req;
    int m_id;

    function automatic logic [10:0] obs();
        return {bus.ei_req, bus.irq_id, bus.pending, bus.overrun};
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [N-1:0] p, o;
        for (int i = 0; i < N; i++) begin
            p[i] = m_pend[i];
            o[i] = m_ovr[i];
        end
        return {m_req, IW'(m_id), p, o};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_per[i] = DEF; m_en[i] = (i == 0);
            m_pend[i] = 0; m_ovr[i] = 0;
        end
        m_phase = 0; m_req = 0; m_id = 0;
    endtask

    task automatic model_step();
        bit tk[N];
        int served;
        int first;
        served = (m_phase == 1 && bus.ack) ? m_id : -1;
        first = -1;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && first < 0) first = i;
        for (int i = 0; i < N; i++) begin
            bit hit;
            hit = bus.cfg_we && (int'(bus.cfg_idx) == i);
            tk[i] = !hit && m_en[i] && (m_cnt[i] == m_per[i]);
            if (hit) begin
                m_per[i] = int'(bus.cfg_period);
                m_cnt[i] = 0;
            end else if (!m_en[i] || tk[i]) m_cnt[i] = 0;
            else m_cnt[i] = (m_cnt[i] + 1) % (1 << W);
        end
        for (int i = 0; i < N; i++) begin
            bool_upd(i, tk[i], served);
        end
        case (m_phase)
            0: if (first >= 0) begin m_phase = 1; m_req = 1; m_id = first; end
            1: if (bus.ack) begin m_phase = 2; m_req = 0; end
            default: m_phase = 0;
        endcase
        if (bus.en_we)
            for (int i = 0; i < N; i++) m_en[i] = bus.en_wdata[i];
    endtask

    task automatic bool_upd(input int i, input bit tk, input int served);
        bit still;
        still = m_pend[i] && (i != served);
        m_ovr[i]  = (bus.ovr_clr ? 1'b0 : m_ovr[i]) | (tk && still);
        m_pend[i] = still || tk;
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
        bus.cfg_we = 0; bus.en_we = 0; bus.ack = 0; bus.ovr_clr = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task automatic write_cfg(input int idx, input int per);
        bus.cfg_we = 1; bus.cfg_idx = IW'(idx); bus.cfg_period = W'(per);
        adv();
    endtask

    task automatic write_en(input logic [N-1:0] m);
        bus.en_we = 1; bus.en_wdata = m;
        adv();
    endtask

    task automatic test_reset();
        int n;
        #1;
        checks++;
        if (obs() !== 11'h0) begin
            errors++; $display("FAIL reset_state: got %h exp %h", obs(), 11'h0);
        end
        @(posedge clk); #1; reset_n = 1;
        n = 0;
        while (n < 7000) begin
            adv(); n++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL reset_run: got %h exp %h", obs(), exp_vec());
            end
            if (bus.ei_req) break;
        end
        // Rises on the 6251st edge after release, i.e. visible during clk 6252.
        checks++;
        if (n !== 6251 || bus.irq_id !== 2'd0) begin
            errors++; $display("FAIL first_req: got edge %0d id %0d exp edge 6251 id 0", n, bus.irq_id);
        end
        bus.ack = 1; adv();
        checks++;
        if (bus.ei_req !== 1'b0) begin
            errors++; $display("FAIL ack_drop: got %b exp 0", bus.ei_req);
        end
    endtask

    task automatic test_two_src();
        do_reset();
        write_cfg(0, 3);
        write_cfg(1, 5);
        write_en(4'b0011);
        repeat (10) begin
            adv();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL two_src: got %h exp %h", obs(), exp_vec());
            end
        end
        checks++;
        if (bus.ei_req !== 1'b1 || bus.irq_id !== 2'd0 || bus.pending[1] !== 1'b1) begin
            errors++; $display("FAIL two_src_pres: got req %b id %0d pend %b exp 1 0 x1xx", bus.ei_req, bus.irq_id, bus.pending);
        end
        bus.ack = 1;
        repeat (6) begin
            adv();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL two_src_ack: got %h exp %h", obs(), exp_vec());
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        write_en(4'b0000);
        write_cfg(2, 0);
        write_en(4'b0100);
        repeat (4) begin
            adv();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL ovr_run: got %h exp %h", obs(), exp_vec());
            end
        end
        checks++;
        if (bus.pending[2] !== 1'b1 || bus.overrun[2] !== 1'b1) begin
            errors++; $display("FAIL ovr_set: got pend %b ovr %b exp bit2 set", bus.pending, bus.overrun);
        end
        bus.ovr_clr = 1; adv();
        checks++;
        if (bus.overrun[2] !== 1'b1) begin
            errors++; $display("FAIL ovr_set_wins: got %b exp 1", bus.overrun[2]);
        end
        write_en(4'b0000);
        bus.ovr_clr = 1; adv();
        checks++;
        if (bus.overrun !== 4'b0000 || bus.pending[2] !== 1'b1) begin
            errors++; $display("FAIL ovr_clear: got ovr %b pend %b exp 0000 x1xx", bus.overrun, bus.pending);
        end
        write_en(4'b0100);
        repeat (3) begin
            adv();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL ovr_reset: got %h exp %h", obs(), exp_vec());
            end
        end
        checks++;
        if (bus.overrun[2] !== 1'b1) begin
            errors++; $display("FAIL ovr_reassert: got %b exp 1", bus.overrun[2]);
        end
    endtask

    task automatic test_ack_tick();
        logic [N-1:0] ovr_before;
        int n;
        do_reset();
        write_en(4'b0000);
        write_cfg(2, 0);
        write_en(4'b0100);
        n = 0;
        while (!bus.ei_req && n < 10) begin adv(); n++; end
        checks++;
        if (bus.ei_req !== 1'b1 || bus.irq_id !== 2'd2) begin
            errors++; $display("FAIL ackt_pres: got req %b id %0d exp 1 2", bus.ei_req, bus.irq_id);
        end
        ovr_before = bus.overrun;
        bus.ack = 1; adv();
        checks++;
        if (bus.ei_req !== 1'b0 || bus.pending[2] !== 1'b1 || bus.overrun !== ovr_before) begin
            errors++; $display("FAIL ackt_keep: got req %b pend %b ovr %b exp 0 x1xx %b", bus.ei_req, bus.pending, bus.overrun, ovr_before);
        end
        adv();
        checks++;
        if (bus.ei_req !== 1'b0) begin
            errors++; $display("FAIL ackt_gap: got %b exp 0", bus.ei_req);
        end
        adv();
        checks++;
        if (bus.ei_req !== 1'b1 || bus.irq_id !== 2'd2) begin
            errors++; $display("FAIL ackt_repres: got req %b id %0d exp 1 2", bus.ei_req, bus.irq_id);
        end
    endtask

    task automatic test_cfg_write();
        int n;
        do_reset();
        repeat (7) adv();
        write_cfg(0, 10);
        n = 0;
        while (!bus.pending[0] && n < 20) begin
            adv(); n++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL cfg_run: got %h exp %h", obs(), exp_vec());
            end
        end
        checks++;
        if (n !== 11) begin
            errors++; $display("FAIL cfg_tick_delay: got %0d exp 11", n);
        end
        write_en(4'b0000);
        checks++;
        if (bus.ei_req !== 1'b1 || bus.irq_id !== 2'd0) begin
            errors++; $display("FAIL cfg_dis_pres: got req %b id %0d exp 1 0", bus.ei_req, bus.irq_id);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (3000) begin
            bus.cfg_we     = ($urandom_range(0, 15) == 0);
            bus.cfg_idx    = IW'($urandom_range(0, N - 1));
            bus.cfg_period = W'($urandom_range(0, 12));
            bus.en_we      = ($urandom_range(0, 31) == 0);
            bus.en_wdata   = N'($urandom);
            bus.ack        = ($urandom_range(0, 3) == 0);
            bus.ovr_clr    = ($urandom_range(0, 15) == 0);
            adv();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL random: got %h exp %h", obs(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        write_en(4'b0000);
        write_cfg(1, 2);
        write_en(4'b0010);
        n = 0;
        while (!bus.ei_req && n < 10) begin adv(); n++; end
        #2;
        reset_n = 0;
        model_reset();
        #1;
        checks++;
        if (obs() !== 11'h0) begin
            errors++; $display("FAIL async_reset: got %h exp %h", obs(), 11'h0);
        end
        @(posedge clk); #1;
        reset_n = 1;
        n = 0;
        while (n < 7000) begin
            bus.ack = ($urandom_range(0, 1) == 1);
            adv(); n++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL post_reset: got %h exp %h", obs(), exp_vec());
            end
            if (bus.ei_req) break;
        end
        checks++;
        if (n !== 6251) begin
            errors++; $display("FAIL post_reset_period: got edge %0d exp 6251", n);
        end
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_period = '0;
        bus.en_we = 0; bus.en_wdata = '0; bus.ack = 0; bus.ovr_clr = 0;
        model_reset();
        test_reset();
        test_two_src();
        test_overrun();
        test_ack_tick();
        test_cfg_write();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
